// File: rtl/rca_reg_addr_config.sv
// Per-RCA CPU register address tables (source, non-feedback and feedback destination)
// with a config write port, a 1-cycle lookup port and a sequential flush.
module rca_reg_addr_config #(
    parameter int NUM_RCAS        = 4,
    parameter int NUM_READ_PORTS  = 5,
    parameter int NUM_WRITE_PORTS = 5
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         cfg_valid,
    output logic                         cfg_ready,
    input  logic                         cfg_fb,
    input  logic [$clog2(NUM_RCAS)-1:0]  cfg_rca_sel,
    input  logic [$clog2(NUM_READ_PORTS)-1:0] cfg_port_sel,
    input  logic                         cfg_src_dest,
    input  logic [4:0]                   cfg_reg_addr,
    input  logic                         lkp_valid,
    input  logic [$clog2(NUM_RCAS)-1:0]  lkp_rca_sel,
    input  logic                         lkp_fb,
    output logic                         lkp_done,
    output logic [5*NUM_READ_PORTS-1:0]  lkp_src_addrs,
    output logic [5*NUM_WRITE_PORTS-1:0] lkp_dest_addrs,
    output logic [NUM_RCAS-1:0]          rca_configured,
    input  logic                         flush_req,
    output logic                         flush_done
);

    localparam int RW = $clog2(NUM_RCAS);
    localparam int MW = NUM_READ_PORTS + NUM_WRITE_PORTS;

    typedef enum logic {IDLE, FLUSH} state_t;

    state_t          state;
    logic [RW-1:0]   flush_cnt;

    logic [4:0]      src_tab  [NUM_RCAS][NUM_READ_PORTS];
    logic [4:0]      nfb_tab  [NUM_RCAS][NUM_WRITE_PORTS];
    logic [4:0]      fb_tab   [NUM_RCAS][NUM_WRITE_PORTS];
    logic [MW-1:0]   mask     [NUM_RCAS];
    logic [MW-1:0]   mask_nxt [NUM_RCAS];

    logic                       wr_acc, wr_src, wr_nfb, wr_fb, lkp_hit;
    logic [NUM_RCAS-1:0]        rca_hit, flush_clr;
    logic [5*NUM_READ_PORTS-1:0]  src_rd;
    logic [5*NUM_WRITE_PORTS-1:0] dest_rd;

    assign cfg_ready = (state == IDLE);

    // Out-of-range port selects are accepted but qualify no table entry.
    always_comb begin
        wr_acc  = cfg_valid & cfg_ready;
        wr_src  = wr_acc & ~cfg_src_dest & (32'(cfg_port_sel) < NUM_READ_PORTS);
        wr_nfb  = wr_acc & cfg_src_dest & ~cfg_fb & (32'(cfg_port_sel) < NUM_WRITE_PORTS);
        wr_fb   = wr_acc & cfg_src_dest & cfg_fb & (32'(cfg_port_sel) < NUM_WRITE_PORTS);
        lkp_hit = (cfg_rca_sel == lkp_rca_sel);
        rca_hit   = '0;
        flush_clr = '0;
        for (int unsigned r = 0; r < NUM_RCAS; r++) begin
            rca_hit[r]   = (32'(cfg_rca_sel) == r);
            flush_clr[r] = (state == FLUSH) && (32'(flush_cnt) == r);
        end
    end

    always_comb begin
        for (int unsigned r = 0; r < NUM_RCAS; r++) begin
            mask_nxt[r] = mask[r];
            if (flush_clr[r]) begin
                mask_nxt[r] = '0;
            end else if (rca_hit[r]) begin
                for (int unsigned p = 0; p < NUM_READ_PORTS; p++)
                    if (wr_src && 32'(cfg_port_sel) == p) mask_nxt[r][p] = 1'b1;
                for (int unsigned p = 0; p < NUM_WRITE_PORTS; p++)
                    if (wr_nfb && 32'(cfg_port_sel) == p) mask_nxt[r][NUM_READ_PORTS+p] = 1'b1;
            end
        end
    end

    // Read mux with write-first forwarding from a same-cycle accepted write.
    always_comb begin
        src_rd  = '0;
        dest_rd = '0;
        for (int unsigned p = 0; p < NUM_READ_PORTS; p++) begin
            src_rd[5*p +: 5] = src_tab[lkp_rca_sel][p];
            if (wr_src && lkp_hit && 32'(cfg_port_sel) == p)
                src_rd[5*p +: 5] = cfg_reg_addr;
        end
        for (int unsigned p = 0; p < NUM_WRITE_PORTS; p++) begin
            dest_rd[5*p +: 5] = lkp_fb ? fb_tab[lkp_rca_sel][p] : nfb_tab[lkp_rca_sel][p];
            if ((lkp_fb ? wr_fb : wr_nfb) && lkp_hit && 32'(cfg_port_sel) == p)
                dest_rd[5*p +: 5] = cfg_reg_addr;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            flush_cnt      <= '0;
            flush_done     <= 1'b0;
            lkp_done       <= 1'b0;
            lkp_src_addrs  <= '0;
            lkp_dest_addrs <= '0;
            rca_configured <= '0;
            for (int unsigned r = 0; r < NUM_RCAS; r++) begin
                mask[r] <= '0;
                for (int unsigned p = 0; p < NUM_READ_PORTS; p++) src_tab[r][p] <= '0;
                for (int unsigned p = 0; p < NUM_WRITE_PORTS; p++) begin
                    nfb_tab[r][p] <= '0;
                    fb_tab[r][p]  <= '0;
                end
            end
        end else begin
            flush_done <= 1'b0;
            lkp_done   <= lkp_valid;
            if (lkp_valid) begin
                lkp_src_addrs  <= src_rd;
                lkp_dest_addrs <= dest_rd;
            end

            for (int unsigned r = 0; r < NUM_RCAS; r++) begin
                mask[r]           <= mask_nxt[r];
                rca_configured[r] <= &mask_nxt[r];
                for (int unsigned p = 0; p < NUM_READ_PORTS; p++) begin
                    if (flush_clr[r])
                        src_tab[r][p] <= '0;
                    else if (wr_src && rca_hit[r] && 32'(cfg_port_sel) == p)
                        src_tab[r][p] <= cfg_reg_addr;
                end
                for (int unsigned p = 0; p < NUM_WRITE_PORTS; p++) begin
                    if (flush_clr[r]) begin
                        nfb_tab[r][p] <= '0;
                        fb_tab[r][p]  <= '0;
                    end else if (rca_hit[r] && 32'(cfg_port_sel) == p) begin
                        if (wr_nfb) nfb_tab[r][p] <= cfg_reg_addr;
                        if (wr_fb)  fb_tab[r][p]  <= cfg_reg_addr;
                    end
                end
            end

            case (state)
                IDLE: begin
                    if (flush_req) begin
                        state     <= FLUSH;
                        flush_cnt <= '0;
                    end
                end
                FLUSH: begin
                    if (32'(flush_cnt) == NUM_RCAS - 1) begin
                        state      <= IDLE;
                        flush_done <= 1'b1;
                    end else begin
                        flush_cnt <= flush_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rca_reg_addr_config.sv
// Directed bench for rca_reg_addr_config: writes, lookups, forwarding, flush and reset-abort.
module tb_rca_reg_addr_config;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cfg_valid, cfg_ready, cfg_fb, cfg_src_dest;
    logic [1:0]  cfg_rca_sel;
    logic [2:0]  cfg_port_sel;
    logic [4:0]  cfg_reg_addr;
    logic        lkp_valid, lkp_fb, lkp_done;
    logic [1:0]  lkp_rca_sel;
    logic [24:0] lkp_src_addrs, lkp_dest_addrs;
    logic [3:0]  rca_configured;
    logic        flush_req, flush_done;

    int vectors = 0;
    int miscompares = 0;

    rca_reg_addr_config #(.NUM_RCAS(4), .NUM_READ_PORTS(5), .NUM_WRITE_PORTS(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_fb(cfg_fb),
        .cfg_rca_sel(cfg_rca_sel), .cfg_port_sel(cfg_port_sel),
        .cfg_src_dest(cfg_src_dest), .cfg_reg_addr(cfg_reg_addr),
        .lkp_valid(lkp_valid), .lkp_rca_sel(lkp_rca_sel), .lkp_fb(lkp_fb),
        .lkp_done(lkp_done), .lkp_src_addrs(lkp_src_addrs),
        .lkp_dest_addrs(lkp_dest_addrs), .rca_configured(rca_configured),
        .flush_req(flush_req), .flush_done(flush_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [24:0] pk(input int a4, a3, a2, a1, a0);
        return {5'(a4), 5'(a3), 5'(a2), 5'(a1), 5'(a0)};
    endfunction

    task automatic set_wr(input logic sd, fb, input int rca, port, addr);
        cfg_valid    = 1'b1;
        cfg_src_dest = sd;
        cfg_fb       = fb;
        cfg_rca_sel  = 2'(rca);
        cfg_port_sel = 3'(port);
        cfg_reg_addr = 5'(addr);
    endtask

    task automatic wr(input logic sd, fb, input int rca, port, addr);
        set_wr(sd, fb, rca, port, addr);
        tick();
        cfg_valid = 1'b0;
    endtask

    task automatic set_lkp(input int rca, input logic fb);
        lkp_valid   = 1'b1;
        lkp_rca_sel = 2'(rca);
        lkp_fb      = fb;
    endtask

    task automatic lkp(input int rca, input logic fb);
        set_lkp(rca, fb);
        tick();
        lkp_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; cfg_valid = 0; cfg_fb = 0; cfg_src_dest = 0; cfg_rca_sel = 0;
        cfg_port_sel = 0; cfg_reg_addr = 0; lkp_valid = 0; lkp_rca_sel = 0; lkp_fb = 0;
        flush_req = 0;
        repeat (2) tick();
        chk("rst_cfg_ready", cfg_ready, 1);
        chk("rst_lkp_done", lkp_done, 0);
        chk("rst_flush_done", flush_done, 0);
        chk("rst_configured", rca_configured, 0);
        chk("rst_src", lkp_src_addrs, 0);
        chk("rst_dest", lkp_dest_addrs, 0);
        rst_n = 1'b1;
        tick();

        // RCA1 full configuration
        for (int p = 0; p < 5; p++) wr(0, 0, 1, p, 5 + p);
        for (int p = 0; p < 4; p++) wr(1, 0, 1, p, 10 + p);
        chk("cfg_partial", rca_configured, 4'b0000);
        wr(1, 0, 1, 4, 14);
        chk("cfg_rca1", rca_configured, 4'b0010);
        lkp(1, 0);
        chk("lkp1_done", lkp_done, 1);
        chk("lkp1_src", lkp_src_addrs, pk(9, 8, 7, 6, 5));
        chk("lkp1_dest", lkp_dest_addrs, pk(14, 13, 12, 11, 10));
        tick();
        chk("lkp1_done_pulse", lkp_done, 0);
        chk("lkp1_hold", lkp_src_addrs, pk(9, 8, 7, 6, 5));

        // feedback vs non-feedback table
        wr(1, 1, 0, 2, 31);
        lkp(0, 1);
        chk("fb_dest", lkp_dest_addrs, pk(0, 0, 31, 0, 0));
        chk("fb_src", lkp_src_addrs, 0);
        lkp(0, 0);
        chk("nfb_dest", lkp_dest_addrs, 0);
        chk("fb_no_cfg", rca_configured, 4'b0010);

        // write-first forwarding
        set_wr(0, 0, 2, 3, 17); set_lkp(2, 0);
        tick(); cfg_valid = 0; lkp_valid = 0;
        chk("fwd_src", lkp_src_addrs, pk(0, 17, 0, 0, 0));
        set_wr(1, 0, 2, 0, 3); set_lkp(2, 0);
        tick(); cfg_valid = 0; lkp_valid = 0;
        chk("fwd_dest", lkp_dest_addrs, pk(0, 0, 0, 0, 3));
        set_wr(1, 0, 2, 1, 4); set_lkp(2, 1);
        tick(); cfg_valid = 0; lkp_valid = 0;
        chk("fwd_other_tbl", lkp_dest_addrs, 0);

        // out-of-range port selects
        set_wr(0, 0, 1, 7, 1);
        chk("oor_ready", cfg_ready, 1);
        tick(); cfg_valid = 0;
        wr(0, 0, 1, 5, 2);
        wr(1, 0, 1, 7, 3);
        wr(1, 1, 1, 5, 4);
        lkp(1, 0);
        chk("oor_src", lkp_src_addrs, pk(9, 8, 7, 6, 5));
        chk("oor_dest", lkp_dest_addrs, pk(14, 13, 12, 11, 10));
        chk("oor_cfg", rca_configured, 4'b0010);
        lkp(1, 1);
        chk("oor_fb", lkp_dest_addrs, 0);

        // RCA3 configured, last write coincides with flush_req
        for (int p = 0; p < 5; p++) wr(0, 0, 3, p, 20 + p);
        for (int p = 0; p < 4; p++) wr(1, 0, 3, p, 25 + p);
        set_wr(1, 0, 3, 4, 29); flush_req = 1'b1;
        tick(); cfg_valid = 0;
        chk("fl0_ready", cfg_ready, 0);
        chk("fl0_cfg", rca_configured, 4'b1010);
        chk("fl0_done", flush_done, 0);
        set_lkp(1, 0);
        tick(); flush_req = 0;
        chk("fl1_ready", cfg_ready, 0);
        chk("fl1_lkp_done", lkp_done, 1);
        chk("fl1_src", lkp_src_addrs, pk(9, 8, 7, 6, 5));
        set_lkp(0, 1);
        tick();
        chk("fl2_ready", cfg_ready, 0);
        chk("fl2_dest", lkp_dest_addrs, 0);
        chk("fl2_cfg", rca_configured, 4'b1000);
        set_lkp(3, 0);
        tick(); lkp_valid = 0;
        chk("fl3_ready", cfg_ready, 0);
        chk("fl3_done", flush_done, 0);
        chk("fl3_src", lkp_src_addrs, pk(24, 23, 22, 21, 20));
        chk("fl3_dest", lkp_dest_addrs, pk(29, 28, 27, 26, 25));
        tick();
        chk("fl4_ready", cfg_ready, 1);
        chk("fl4_done", flush_done, 1);
        chk("fl4_cfg", rca_configured, 0);
        tick();
        chk("fl5_done", flush_done, 0);
        chk("fl5_ready", cfg_ready, 1);
        for (int r = 0; r < 4; r++) begin
            lkp(r, 0);
            chk("post_src", lkp_src_addrs, 0);
            chk("post_nfb", lkp_dest_addrs, 0);
            lkp(r, 1);
            chk("post_fb", lkp_dest_addrs, 0);
        end

        // reset during flush cycle 2
        for (int p = 0; p < 5; p++) begin
            wr(0, 0, 2, p, 1 + p);
            wr(1, 0, 2, p, 6 + p);
        end
        chk("pre_rst_cfg", rca_configured, 4'b0100);
        lkp(2, 0);
        chk("pre_rst_src", lkp_src_addrs, pk(5, 4, 3, 2, 1));
        flush_req = 1'b1;
        tick(); flush_req = 0;
        tick();
        chk("ab_ready_low", cfg_ready, 0);
        rst_n = 1'b0;
        #1;
        chk("ab_src", lkp_src_addrs, 0);
        chk("ab_dest", lkp_dest_addrs, 0);
        chk("ab_cfg", rca_configured, 0);
        chk("ab_lkp_done", lkp_done, 0);
        chk("ab_ready", cfg_ready, 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("ab_flush_done", flush_done, 0);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("ab_post_ready", cfg_ready, 1);
            chk("ab_post_done", flush_done, 0);
        end
        lkp(2, 0);
        chk("ab_tbl_clear", lkp_src_addrs, 0);
        wr(0, 0, 2, 0, 7);
        lkp(2, 0);
        chk("ab_wr_after", lkp_src_addrs, pk(0, 0, 0, 0, 7));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/rca_reg_addr_config.md
RCA_REG_ADDR_CONFIG -- requirements
Module: rca_reg_addr_config

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- NUM_RCAS, 4, number of reconfigurable accelerators.
- NUM_READ_PORTS, 5, CPU source ports per RCA.
- NUM_WRITE_PORTS, 5, CPU destination ports per RCA.
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- clk, in, 1, sole clock.
- rst_n, in, 1, asynchronous active-low reset.
- cfg_valid, in, 1, config write request.
- cfg_ready, out, 1, config write accepted when cfg_valid and cfg_ready are both high.
- cfg_fb, in, 1, 1 = feedback destination table, 0 = non-feedback table.
- cfg_rca_sel, in, $clog2(NUM_RCAS), target RCA.
- cfg_port_sel, in, $clog2(NUM_READ_PORTS), port index.
- cfg_src_dest, in, 1, 0 = source port, 1 = destination port.
- cfg_reg_addr, in, 5, CPU register address.
- lkp_valid, in, 1, lookup request.
- lkp_rca_sel, in, $clog2(NUM_RCAS), RCA to look up.
- lkp_fb, in, 1, selects the feedback destination table.
- lkp_done, out, 1, lookup result valid.
- lkp_src_addrs, out, 5*NUM_READ_PORTS, packed source addresses, port 0 in the LSBs.
- lkp_dest_addrs, out, 5*NUM_WRITE_PORTS, packed destination addresses, port 0 in the LSBs.
- rca_configured, out, NUM_RCAS, per-RCA "all ports written" flag.
- flush_req, in, 1, clear all tables.
- flush_done, out, 1, one-cycle pulse at the end of a flush.

Function
REQ-003 The block SHALL hold three tables per RCA: src[NUM_READ_PORTS], dest_nfb[NUM_WRITE_PORTS] and dest_fb[NUM_WRITE_PORTS], each entry 5 bits.
REQ-004 An accepted write SHALL update exactly one entry on the next rising edge:
- cfg_src_dest=0 writes src[cfg_port_sel].
- cfg_src_dest=1 and cfg_fb=0 writes dest_nfb[cfg_port_sel].
- cfg_src_dest=1 and cfg_fb=1 writes dest_fb[cfg_port_sel].
REQ-005 cfg_ready SHALL be high in the IDLE state and low in the FLUSH state.
REQ-006 A write with cfg_port_sel >= its table size SHALL be accepted and discarded, leaving all state unchanged.
REQ-007 The block SHALL keep a written-mask per RCA covering the src and dest_nfb entries.
REQ-008 rca_configured[r] SHALL be registered and SHALL go high the cycle after the final required entry of RCA r is written.
REQ-009 Lookup latency SHALL be 1 cycle: lkp_valid sampled at edge N gives lkp_done=1 with the addresses valid after edge N. Outputs hold their values until the next lookup; lkp_done is a single-cycle pulse.
REQ-010 Lookup destination table: lkp_fb=1 returns dest_fb; lkp_fb=0 returns dest_nfb.
REQ-011 Simultaneous accepted write and lookup to the same RCA and table SHALL return the newly written value (write-first forwarding).
REQ-012 The FSM SHALL have two states, IDLE and FLUSH.
- IDLE to FLUSH on flush_req, with flush counter = 0.
- FLUSH clears all three tables and the written-mask of RCA[counter] each cycle, then increments the counter.
- After clearing RCA NUM_RCAS-1, the FSM SHALL pulse flush_done and return to IDLE.
- A flush SHALL take exactly NUM_RCAS cycles.
REQ-013 flush_req while in FLUSH SHALL be ignored.
REQ-014 A cfg_valid arriving in the same cycle as flush_req SHALL be accepted: the write lands, then the flush clears it.
REQ-015 Lookups during FLUSH SHALL complete normally. An RCA's cleared entries read as 0 from the cycle after it is cleared.
REQ-016 rca_configured[r] SHALL drop to 0 the cycle after RCA r is cleared.

Reset
REQ-017 On rst_n low, the following SHALL be cleared asynchronously: all table entries and masks = 0, state = IDLE, counter = 0, lkp_done = 0, flush_done = 0, rca_configured = 0, lkp_src_addrs = 0, lkp_dest_addrs = 0. cfg_ready SHALL read 1 while in reset.
REQ-018 Reset asserted mid-flush SHALL abort the flush without asserting flush_done.
REQ-019 State SHALL be updated only on rising edges of clk after rst_n deasserts.

Verification
REQ-020 Write RCA1 src ports 0..4 with addresses 5..9 and dest_nfb ports 0..4 with addresses 10..14 -> rca_configured = 4'b0010 the cycle after the last write. Then lookup RCA1 with lkp_fb=0 -> one cycle later lkp_done=1, src = {9,8,7,6,5}, dest = {14,13,12,11,10}.
REQ-021 Write RCA0 dest_fb port 2 = 31, then lookup RCA0 with lkp_fb=1 -> dest port 2 = 31. Same lookup with lkp_fb=0 -> dest port 2 = 0.
REQ-022 Write RCA2 src port 3 = 17 in the same cycle as a lookup of RCA2 -> lkp_src_addrs port 3 = 17.
REQ-023 flush_req with NUM_RCAS=4 -> cfg_ready low for exactly 4 cycles, flush_done pulses once, all lookups then return 0, rca_configured = 0.
REQ-024 Write with cfg_port_sel = 7 -> accepted (cfg_ready=1), no table change, rca_configured unchanged.
REQ-025 Assert rst_n low during cycle 2 of a flush -> all outputs zero, no flush_done, state IDLE, and cfg_ready=1 after release.
